// File: rtl/sdr_stream_mux.sv
// N-channel round-robin packetizer: header word plus PKT_WORDS IQ data words per
// packet, with a sequence number per channel and a sticky mid-packet underrun flag.
module sdr_stream_mux #(
  parameter int unsigned NUM_CH        = 2,
  parameter int unsigned IQ_PAIR_WIDTH = 24,
  parameter int unsigned FT_DATA_WIDTH = 32,
  parameter int unsigned PKT_WORDS     = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_CH-1:0]               ch_en,
  input  logic [NUM_CH*IQ_PAIR_WIDTH-1:0] ch_data,
  input  logic [NUM_CH-1:0]               ch_empty,
  input  logic [NUM_CH-1:0]               ch_enough,
  output logic [NUM_CH-1:0]               ch_rd,
  output logic [FT_DATA_WIDTH-1:0]        out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_last,
  output logic                            underrun,
  output logic [3:0]                      active_ch
);

  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CNT_W = $clog2(PKT_WORDS);
  localparam int unsigned SEQ_W = 12;

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t                    state_q, state_d;
  logic [CH_W-1:0]           cur_q, cur_d;
  logic [CH_W-1:0]           rr_q, rr_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [NUM_CH*SEQ_W-1:0]   seq_q, seq_d;
  logic                      underrun_q, underrun_d;

  logic [NUM_CH-1:0]         eligible;
  logic                      grant_found;
  logic [CH_W-1:0]           grant_ch;
  logic [SEQ_W-1:0]          cur_seq;
  logic [IQ_PAIR_WIDTH-1:0]  cur_iq;
  logic                      cur_empty;
  logic                      last_word;

  assign eligible  = ch_en & ch_enough;
  assign cur_seq   = seq_q[32'(cur_q)*SEQ_W +: SEQ_W];
  assign cur_iq    = ch_data[32'(cur_q)*IQ_PAIR_WIDTH +: IQ_PAIR_WIDTH];
  assign cur_empty = ch_empty[cur_q];
  assign last_word = (cnt_q == CNT_W'(PKT_WORDS - 1));
  assign underrun  = underrun_q;
  assign active_ch = 4'(cur_q);

  // Round-robin search starting just after the last served channel
  always_comb begin
    grant_found = 1'b0;
    grant_ch    = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      if (!grant_found && eligible[CH_W'((32'(rr_q) + k) % NUM_CH)]) begin
        grant_found = 1'b1;
        grant_ch    = CH_W'((32'(rr_q) + k) % NUM_CH);
      end
    end
  end

  // Next-state and output decode; data-phase valid/rd follow the FIFO head directly
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    seq_d      = seq_q;
    underrun_d = underrun_q;
    out_valid  = 1'b0;
    out_data   = '0;
    out_last   = 1'b0;
    ch_rd      = '0;
    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          cur_d   = grant_ch;
          state_d = HDR;
        end
      end
      HDR: begin
        out_valid = 1'b1;
        out_data  = FT_DATA_WIDTH'({8'hA5, 4'(cur_q), cur_seq, 8'(PKT_WORDS - 1)});
        if (out_ready) begin
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        out_valid = !cur_empty;
        out_data  = FT_DATA_WIDTH'({8'(cur_q), cur_iq});
        out_last  = last_word;
        if (cur_empty) begin
          underrun_d = 1'b1;
        end else if (out_ready) begin
          ch_rd[cur_q] = 1'b1;
          cnt_d        = cnt_q + CNT_W'(1);
          if (last_word) begin
            seq_d[32'(cur_q)*SEQ_W +: SEQ_W] = cur_seq + SEQ_W'(1);
            rr_d    = cur_q;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A reset abandons the packet in the very cycle it arrives
    if (reset) begin
      out_valid = 1'b0;
      ch_rd     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      rr_q       <= CH_W'(NUM_CH - 1);
      cnt_q      <= '0;
      seq_q      <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      seq_q      <= seq_d;
      underrun_q <= underrun_d;
    end
  end

endmodule

// File: doc/sdr_stream_mux.md
Name: sdr_stream_mux

Overview:
- Parametrised N-channel packetizer between the per-channel AFE RX FIFOs (a2f side) and the FT600 write path, all in the ft_clk domain.
- Arbitrates round-robin among enabled channels that hold a full packet's worth of IQ pairs.
- Emits each packet as one sync/header word followed by PKT_WORDS data words, with per-channel sequence numbers.
- Generalises the current single-channel a2f path to NUM_CH channels with framing, flow control and underrun detection.

Parameters:
- NUM_CH, 2, number of input channels; range 1..16.
- IQ_PAIR_WIDTH, 24, width of one IQ pair word from a channel FIFO.
- FT_DATA_WIDTH, 32, output word width; must be >= 32 and >= IQ_PAIR_WIDTH+8.
- PKT_WORDS, 32, data words per packet; range 2..256.

Ports:
- clk  in  1  ft_clk domain clock.
- reset  in  1  synchronous, active-high reset.
- ch_en  in  NUM_CH  per-channel enable mask.
- ch_data  in  NUM_CH*IQ_PAIR_WIDTH  FWFT FIFO heads; channel i occupies [i*IQ_PAIR_WIDTH +: IQ_PAIR_WIDTH].
- ch_empty  in  NUM_CH  FIFO empty flags.
- ch_enough  in  NUM_CH  FIFO holds >= PKT_WORDS words.
- ch_rd  out  NUM_CH  pop strobe (FWFT: pops the current head).
- out_data  out  FT_DATA_WIDTH  word to the FT600 FSM.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  FSM accepts the word this cycle.
- out_last  out  1  marks the final data word of a packet.
- underrun  out  1  sticky: a FIFO went empty mid-packet.
- active_ch  out  4  channel currently granted.

Behaviour:
- Reset (synchronous, active-high, on clk): state=IDLE; ch_rd=0; out_valid=0; out_last=0; out_data=0; underrun=0; active_ch=0; all sequence counters=0; rr_ptr=NUM_CH-1.
- Reset asserted mid-packet: abort the packet the same cycle with no further ch_rd. A partially sent packet is not completed.
- Transfer rule: a word transfers when out_valid && out_ready.
- Stability: while out_valid && !out_ready, out_data and out_last hold stable.
- State IDLE:
  - eligible = ch_en & ch_enough.
  - If any bit is set, grant the first eligible channel searching from rr_ptr+1 upward, wrapping modulo NUM_CH.
  - Latch the grant into active_ch; go to HDR.
  - out_valid=0 in IDLE. Minimum one IDLE cycle between packets.
- State HDR:
  - out_valid=1.
  - out_data bits, zero-extended to FT_DATA_WIDTH:
    - [31:24]=8'hA5
    - [23:20]=active_ch
    - [19:8]=seq[active_ch]
    - [7:0]=PKT_WORDS-1
  - On transfer: word counter=0; go to DATA.
- State DATA:
  - out_data = {active_ch[7:0] zero-extended in bits [IQ_PAIR_WIDTH+7:IQ_PAIR_WIDTH], ch_data of active_ch in [IQ_PAIR_WIDTH-1:0]}; upper bits 0.
  - out_valid = !ch_empty[active_ch]. This path is combinational from the FIFO head.
  - ch_rd[active_ch] = out_valid && out_ready (combinational); all other ch_rd bits stay 0.
  - out_last = (counter == PKT_WORDS-1).
  - On each transfer: counter++.
  - On the transfer with out_last: seq[active_ch] += 1 (12-bit, wraps 4095->0); rr_ptr=active_ch; go to IDLE.
- Empty mid-packet: ch_empty[active_ch]=1 in DATA sets underrun (sticky until reset). The FSM stalls with out_valid=0 and resumes when data returns; the packet is never truncated.
- ch_en or ch_enough dropping mid-packet: no effect; the packet completes.
- Simultaneous eligibility: strict round-robin. No channel is granted twice while another eligible channel waits.
- Latency: header is valid the cycle after a grant in IDLE. Best-case packet is 1 IDLE + 1 + PKT_WORDS cycles.

Test Plan:
- NUM_CH=2, PKT_WORDS=4; ch0 enough with data 0x000001..0x000004; out_ready=1 → header 0xA5000003, then 0x00000001..0x00000004 with out_last on the 4th word; exactly 4 ch_rd[0] pulses; next ch0 header 0xA5000103.
- ch0 and ch1 both permanently eligible → packet order ch0, ch1, ch0, ch1; headers carry ch 0/1; each channel's seq increments only on its own packets.
- Toggle out_ready 1-0-1 during HDR and DATA → out_data held stable during stalls; ch_rd pulses only on transfer cycles; no words duplicated or dropped.
- Raise ch_empty[0] for 3 cycles after data word 2 → out_valid=0 for 3 cycles; underrun=1 and stays 1; packet then completes with 4 data words.
- Force 4096 ch0 packets → seq field 0xFFF on packet 4096, 0x000 on packet 4097.
- Assert reset at data word 2 → next cycle out_valid=0, ch_rd=0, underrun=0, seq=0. After release, the first header is 0xA5000003.
- ch_en=2'b10 with both channels enough → only ch1 packets are emitted; ch_rd[0] never asserts.
